// File: rtl/idli_pkg.sv
// Shared constants and types for the idli predicate register file.
package idli_pkg;

    localparam int IDLI_NUM_PREGS = 4;

    typedef logic [$clog2(IDLI_NUM_PREGS)-1:0] preg_t;

    typedef enum logic [1:0] {
        IDLE,
        SAVE,
        RESTORE
    } prf_ctx_state_t;

endpackage

// File: rtl/idli_prf_ctx_fsm_m.sv
// Context save/restore sequencer: state, beat counter and registered
// busy/valid/done flags for the predicate file's serial channel.
module idli_prf_ctx_fsm_m
    import idli_pkg::*;
#(
    parameter int BEATS = 3,
    parameter int CNT_W = 2
) (
    input  logic             gclk,
    input  logic             grst_n,
    input  logic             start_save,
    input  logic             start_restore,
    output prf_ctx_state_t   state,
    output logic [CNT_W-1:0] beat,
    output logic             busy,
    output logic             valid,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
    localparam logic             ONE_BEAT = (BEATS == 1);

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            state <= IDLE;
            beat  <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Save has priority; a simultaneous restore is dropped.
                    if (start_save) begin
                        state <= SAVE;
                        beat  <= '0;
                        busy  <= 1'b1;
                        valid <= 1'b1;
                        done  <= ONE_BEAT;
                    end else if (start_restore) begin
                        state <= RESTORE;
                        beat  <= '0;
                        busy  <= 1'b1;
                        valid <= 1'b0;
                        done  <= ONE_BEAT;
                    end
                end
                SAVE, RESTORE: begin
                    if (beat == LAST) begin
                        state <= IDLE;
                        beat  <= '0;
                        busy  <= 1'b0;
                        valid <= 1'b0;
                        done  <= 1'b0;
                    end else begin
                        beat <= beat + 1'b1;
                        done <= ((beat + 1'b1) == LAST);
                    end
                end
                default: begin
                    state <= IDLE;
                    beat  <= '0;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/idli_prf_ctx_m.sv
// Parametrised predicate register file with hardwired-one top register and a
// serial context save/restore port. Define IDLI_PRF_BYPASS_EN for write-first reads.
module idli_prf_ctx_m
    import idli_pkg::*;
#(
    parameter int NUM_PREGS = IDLI_NUM_PREGS,
    parameter int CHUNK     = 1
) (
    input  logic                         i_prf_gck,
    input  logic                         i_prf_rst_n,
    input  logic [$clog2(NUM_PREGS)-1:0] i_prf_p,
    output logic                         o_prf_p_data,
    input  logic [$clog2(NUM_PREGS)-1:0] i_prf_q,
    output logic                         o_prf_q_data,
    input  logic                         i_prf_q_wr_en,
    input  logic                         i_prf_q_data,
    input  logic                         i_prf_ctx_save,
    input  logic                         i_prf_ctx_restore,
    input  logic [CHUNK-1:0]             i_prf_ctx_data,
    output logic [CHUNK-1:0]             o_prf_ctx_data,
    output logic                         o_prf_ctx_valid,
    output logic                         o_prf_ctx_busy,
    output logic                         o_prf_ctx_done
);

    localparam int W     = NUM_PREGS - 1;
    localparam int IDX_W = $clog2(NUM_PREGS);
    localparam int BEATS = (W + CHUNK - 1) / CHUNK;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SW    = BEATS * CHUNK;
    localparam logic [IDX_W-1:0] HW_IDX = IDX_W'(W);

    prf_ctx_state_t   state;
    logic [CNT_W-1:0] beat;
    logic [W-1:0]     regs;
    logic [SW-1:0]    snap;
    logic [SW-1:0]    stage;
    logic [SW-1:0]    stage_nxt;
    logic [W:0]       rd_vec;
    logic             start_save;
    logic             in_restore;
    logic             commit;
    logic             wr_ok;

    assign start_save = (state == IDLE) && i_prf_ctx_save;
    assign in_restore = (state == RESTORE);
    assign commit     = in_restore && o_prf_ctx_done;
    assign wr_ok      = i_prf_q_wr_en && !in_restore;

    idli_prf_ctx_fsm_m #(
        .BEATS (BEATS),
        .CNT_W (CNT_W)
    ) u_fsm (
        .gclk          (i_prf_gck),
        .grst_n        (i_prf_rst_n),
        .start_save    (i_prf_ctx_save),
        .start_restore (i_prf_ctx_restore),
        .state         (state),
        .beat          (beat),
        .busy          (o_prf_ctx_busy),
        .valid         (o_prf_ctx_valid),
        .done          (o_prf_ctx_done)
    );

    // Current beat merged into staging so the final beat lands in the commit.
    always_comb begin
        stage_nxt = stage;
        stage_nxt[int'(beat)*CHUNK +: CHUNK] = i_prf_ctx_data;
    end

    for (genvar i = 0; i < W; i++) begin : g_reg
        always_ff @(posedge i_prf_gck or negedge i_prf_rst_n) begin
            if (!i_prf_rst_n)
                regs[i] <= 1'b0;
            else if (commit)
                regs[i] <= stage_nxt[i];
            else if (wr_ok && (i_prf_q == IDX_W'(i)))
                regs[i] <= i_prf_q_data;
        end
    end

    always_ff @(posedge i_prf_gck or negedge i_prf_rst_n) begin
        if (!i_prf_rst_n) begin
            snap  <= '0;
            stage <= '0;
        end else begin
            if (start_save)
                snap <= SW'(regs);
            if (in_restore)
                stage <= stage_nxt;
        end
    end

    assign o_prf_ctx_data = o_prf_ctx_valid ? snap[int'(beat)*CHUNK +: CHUNK] : '0;

    assign rd_vec = {1'b1, regs};

`ifdef IDLI_PRF_BYPASS_EN
    always_comb begin
        o_prf_p_data = rd_vec[i_prf_p];
        o_prf_q_data = rd_vec[i_prf_q];
        if (wr_ok && (i_prf_q == i_prf_p) && (i_prf_p != HW_IDX))
            o_prf_p_data = i_prf_q_data;
        if (wr_ok && (i_prf_q != HW_IDX))
            o_prf_q_data = i_prf_q_data;
    end
`else
    logic unused_hw_idx;
    assign unused_hw_idx = ^HW_IDX;
    assign o_prf_p_data  = rd_vec[i_prf_p];
    assign o_prf_q_data  = rd_vec[i_prf_q];
`endif

endmodule

// File: tb/tb_idli_prf_ctx_m.sv
// Bench for idli_prf_ctx_m: a 4x1 and an 8x2 instance, table-driven read/write
// vectors, and scoreboarded save streams around hand-written context sequences.
`timescale 1ns/1ps
module tb_idli_prf_ctx_m;

    logic gck = 1'b0;
    logic rst_n = 1'b0;
    always #5 gck = ~gck;

    logic [1:0] p4, q4;
    logic       wr4, wd4, sv4, rs4, pd4, qd4, vl4, by4, dn4;
    logic [0:0] ci4, co4;
    logic [2:0] p8, q8;
    logic       wr8, wd8, sv8, rs8, pd8, qd8, vl8, by8, dn8;
    logic [1:0] ci8, co8;

    idli_prf_ctx_m #(.NUM_PREGS(4), .CHUNK(1)) u4 (
        .i_prf_gck(gck), .i_prf_rst_n(rst_n),
        .i_prf_p(p4), .o_prf_p_data(pd4), .i_prf_q(q4), .o_prf_q_data(qd4),
        .i_prf_q_wr_en(wr4), .i_prf_q_data(wd4),
        .i_prf_ctx_save(sv4), .i_prf_ctx_restore(rs4), .i_prf_ctx_data(ci4),
        .o_prf_ctx_data(co4), .o_prf_ctx_valid(vl4), .o_prf_ctx_busy(by4),
        .o_prf_ctx_done(dn4)
    );

    idli_prf_ctx_m #(.NUM_PREGS(8), .CHUNK(2)) u8 (
        .i_prf_gck(gck), .i_prf_rst_n(rst_n),
        .i_prf_p(p8), .o_prf_p_data(pd8), .i_prf_q(q8), .o_prf_q_data(qd8),
        .i_prf_q_wr_en(wr8), .i_prf_q_data(wd8),
        .i_prf_ctx_save(sv8), .i_prf_ctx_restore(rs8), .i_prf_ctx_data(ci8),
        .o_prf_ctx_data(co8), .o_prf_ctx_valid(vl8), .o_prf_ctx_busy(by8),
        .o_prf_ctx_done(dn8)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge gck);
        #1;
    endtask

    task automatic rd4(input string nm, input logic [1:0] idx, input logic exp);
        p4 = idx;
        #1;
        chk(nm, {7'd0, pd4}, {7'd0, exp});
    endtask

    // Save-stream scoreboard: expected beats queued when save is driven.
    typedef struct packed {
        logic [1:0] d;
        logic       last;
    } beat_t;
    beat_t q4s[$];
    beat_t q8s[$];
    beat_t b4, b8;

    always @(negedge gck) begin
        if (vl4) begin
            if (q4s.size() == 0) chk("d4 unexpected beat", 8'd1, 8'd0);
            else begin
                b4 = q4s.pop_front();
                chk("d4 save beat", {7'd0, co4}, {6'd0, b4.d});
                chk("d4 save done", {7'd0, dn4}, {7'd0, b4.last});
            end
        end
        if (vl8) begin
            if (q8s.size() == 0) chk("d8 unexpected beat", 8'd1, 8'd0);
            else begin
                b8 = q8s.pop_front();
                chk("d8 save beat", {6'd0, co8}, {6'd0, b8.d});
                chk("d8 save done", {7'd0, dn8}, {7'd0, b8.last});
            end
        end
    end

    typedef struct {
        logic [1:0] p, q;
        logic       wr, wd, ep, eq, epb, eqb;
    } vec_t;
    vec_t tbl[10];

    logic [6:0] m8;
    logic [7:0] v8;
    int nb;

    initial begin
        tbl[0] = '{2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{2'd3, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{2'd1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{2'd1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{2'd3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{2'd2, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        p4 = 0; q4 = 0; wr4 = 0; wd4 = 0; sv4 = 0; rs4 = 0; ci4 = 0;
        p8 = 0; q8 = 0; wr8 = 0; wd8 = 0; sv8 = 0; rs8 = 0; ci8 = 0;

        // Reset state
        tick(); tick();
        for (int i = 0; i < 4; i++) rd4("reset read", 2'(i), (i == 3));
        chk("reset ctx d4", {co4, vl4, by4, dn4, 4'd0}, 8'd0);
        chk("reset ctx d8", {co8, vl8, by8, dn8, 3'd0}, 8'd0);
        @(negedge gck);
        rst_n = 1'b1;
        tick();

        // Read/write vectors on the 4-entry file
        for (int i = 0; i < 10; i++) begin
            p4 = tbl[i].p; q4 = tbl[i].q; wr4 = tbl[i].wr; wd4 = tbl[i].wd;
            @(negedge gck);
`ifdef IDLI_PRF_BYPASS_EN
            chk($sformatf("vec%0d p", i), {7'd0, pd4}, {7'd0, tbl[i].epb});
            chk($sformatf("vec%0d q", i), {7'd0, qd4}, {7'd0, tbl[i].eqb});
`else
            chk($sformatf("vec%0d p", i), {7'd0, pd4}, {7'd0, tbl[i].ep});
            chk($sformatf("vec%0d q", i), {7'd0, qd4}, {7'd0, tbl[i].eq});
`endif
            tick();
        end
        wr4 = 0;

        // Load 8-entry file with 7'b1010011, save with a write during beat 1
        m8 = 7'b1010011;
        foreach (m8[i]) if (m8[i]) begin
            q8 = 3'(i); wd8 = 1'b1; wr8 = 1'b1;
            tick();
        end
        wr8 = 0;
        for (int i = 0; i < 8; i++) begin
            p8 = 3'(i);
            #0.5;
            chk($sformatf("d8 load read %0d", i), {7'd0, pd8}, {7'd0, (i == 7) ? 1'b1 : m8[i]});
        end
        sv8 = 1'b1;
        v8 = {1'b0, m8};
        for (int k = 0; k < 4; k++) q8s.push_back('{v8[k*2 +: 2], (k == 3)});
        tick();
        sv8 = 1'b0;
        chk("d8 busy beat0", {7'd0, by8}, 8'd1);
        tick();
        q8 = 3'd0; wd8 = 1'b0; wr8 = 1'b1;
        m8[0] = 1'b0;
        tick();
        wr8 = 0;
        tick();
        tick();
        p8 = 3'd0;
        #1;
        chk("d8 busy after save", {7'd0, by8}, 8'd0);
        chk("d8 P0 after save", {7'd0, pd8}, 8'd0);
        chk("d8 queue drained", 8'(q8s.size()), 8'd0);

        // Restore 1,0,1 on the 4-entry file with a discarded write mid-stream
        rs4 = 1'b1;
        tick();
        rs4 = 1'b0; ci4 = 1'b1;
        @(negedge gck);
        chk("restore busy", {7'd0, by4}, 8'd1);
        chk("restore done beat0", {7'd0, dn4}, 8'd0);
        chk("restore valid", {7'd0, vl4}, 8'd0);
        tick();
        ci4 = 1'b0; q4 = 2'd1; wd4 = 1'b1; wr4 = 1'b1;
        rd4("restore P1 old beat1", 2'd1, 1'b0);
        tick();
        wr4 = 1'b0; ci4 = 1'b1;
        rd4("restore P1 old beat2", 2'd1, 1'b0);
        @(negedge gck);
        chk("restore done final", {7'd0, dn4}, 8'd1);
        tick();
        rd4("restore P0", 2'd0, 1'b1);
        rd4("restore P1", 2'd1, 1'b0);
        rd4("restore P2", 2'd2, 1'b1);
        chk("restore idle", {7'd0, by4}, 8'd0);

        // Save+restore together, then restore while busy: save only, 3 busy cycles
        ci4 = 1'b0;
        q4s.push_back('{2'd1, 1'b0});
        q4s.push_back('{2'd0, 1'b0});
        q4s.push_back('{2'd1, 1'b1});
        sv4 = 1'b1; rs4 = 1'b1;
        tick();
        sv4 = 1'b0; rs4 = 1'b0;
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge gck);
            if (by4) nb++;
            tick();
            rs4 = (i == 0);
        end
        rs4 = 1'b0;
        chk("busy cycle count", 8'(nb), 8'd3);
        rd4("after save P0", 2'd0, 1'b1);
        rd4("after save P1", 2'd1, 1'b0);
        rd4("after save P2", 2'd2, 1'b1);
        chk("d4 queue drained", 8'(q4s.size()), 8'd0);

        // Reset during restore beat 1 aborts with no commit
        ci4 = 1'b1;
        rs4 = 1'b1;
        tick();
        rs4 = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort busy", {7'd0, by4}, 8'd0);
        chk("abort done", {7'd0, dn4}, 8'd0);
        rd4("abort P0", 2'd0, 1'b0);
        rd4("abort P2", 2'd2, 1'b0);
        tick();
        @(negedge gck);
        chk("abort done held", {7'd0, dn4}, 8'd0);
        rst_n = 1'b1;
        tick();
        rd4("post abort P0", 2'd0, 1'b0);
        for (int k = 0; k < 3; k++) q4s.push_back('{2'd0, (k == 2)});
        sv4 = 1'b1;
        tick();
        sv4 = 1'b0;
        tick(); tick(); tick();
        chk("post abort idle", {7'd0, by4}, 8'd0);
        chk("post abort queue", 8'(q4s.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
